asrv32_writeback_pipe: RTL

// - Parametrised writeback/retire stage for the asrv32 core, XLEN-generic.
// - Accepts one executed instruction per valid/ready handshake; computes rd data, next PC, branch/jump redirect.
// - Owns the architectural PC register and a retired-instruction counter.
// - Sits between execute/memory and the register file / fetch stage.

---
 rtl/asrv32_writeback_pipe.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/asrv32_writeback_pipe.sv
// asrv32_writeback_pipe: retire stage producing rd writeback, next PC and redirect; owns PC and instret.
// Latency: an instruction accepted at edge N has its write strobe, PC, redirect and instret visible after edge N.
// Backpressure: o_ready drops combinationally on i_hold or while a trap is pending; nothing is buffered.
// Optional feature macro ASRV32_WB_MISALIGN_TRAP_EN: trap taken control transfers to non-word-aligned targets.
module asrv32_writeback_pipe #(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] PC_RESET     = '0,
   parameter int              CNT_WIDTH    = 64,
   localparam int             OPCODE_WIDTH = 11
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_valid,
   output logic                    o_ready,
   input  logic                    i_hold,
   input  logic [OPCODE_WIDTH-1:0] i_opcode,
   input  logic [XLEN-1:0]         i_alu_result,
   input  logic [XLEN-1:0]         i_imm,
   input  logic [XLEN-1:0]         i_rs1_data,
   input  logic [XLEN-1:0]         i_load_data,
   input  logic [4:0]              i_rd_addr,
   output logic [XLEN-1:0]         o_rd_data,
   output logic [4:0]              o_rd_addr,
   output logic                    o_wr_rd_en,
   output logic [XLEN-1:0]         o_pc,
   output logic                    o_redirect,
   output logic [CNT_WIDTH-1:0]    o_instret,
   output logic                    o_trap,
   output logic [XLEN-1:0]         o_trap_tval,
   input  logic                    i_trap_ack,
   input  logic [XLEN-1:0]         i_trap_vector
);

   // One-hot opcode bit positions
   localparam int OP_RTYPE  = 0;
   localparam int OP_ITYPE  = 1;
   localparam int OP_LOAD   = 2;
   localparam int OP_STORE  = 3;
   localparam int OP_BRANCH = 4;
   localparam int OP_JAL    = 5;
   localparam int OP_JALR   = 6;
   localparam int OP_LUI    = 7;
   localparam int OP_AUIPC  = 8;
   localparam int OP_SYSTEM = 9;
   localparam int OP_FENCE  = 10;

`ifdef ASRV32_WB_MISALIGN_TRAP_EN
   typedef enum logic {ST_RUN, ST_TRAP} state_t;
`else
   typedef enum logic {ST_RUN} state_t;
`endif

   state_t                 state_q;
   logic [XLEN-1:0]        pc_q;
   logic [XLEN-1:0]        rd_data_q;
   logic [4:0]             rd_addr_q;
   logic                   wr_en_q;
   logic                   redirect_q;
   logic [CNT_WIDTH-1:0]   instret_q;

   logic                   accept;
   logic                   taken;
   logic                   writes_rd;
   logic                   trap_fire;
   logic                   trap_ack_fire;
   logic                   retire;
   logic [XLEN-1:0]        pc_plus4;
   logic [XLEN-1:0]        pc_imm;
   logic [XLEN-1:0]        target;
   logic [XLEN-1:0]        pc_next;
   logic [XLEN-1:0]        rd_data_nxt;

   assign o_ready   = (state_q == ST_RUN) & ~i_hold;
   assign accept    = i_valid & o_ready;

   assign pc_plus4  = pc_q + XLEN'(4);
   assign pc_imm    = pc_q + i_imm;
   assign taken     = i_opcode[OP_JAL] | i_opcode[OP_JALR] |
                      (i_opcode[OP_BRANCH] & i_alu_result[0]);
   assign writes_rd = ~(i_opcode[OP_BRANCH] | i_opcode[OP_STORE] |
                        i_opcode[OP_SYSTEM] | i_opcode[OP_FENCE]) & (i_rd_addr != 5'd0);
   assign pc_next   = taken ? target : pc_plus4;
   assign retire    = accept & ~trap_fire;

   // Control-transfer target; JALR drops bit 0 of its rs1-relative sum
   always_comb begin
      target = pc_imm;
      if (i_opcode[OP_JALR]) begin
         target    = i_rs1_data + i_imm;
         target[0] = 1'b0;
      end
   end

   // Writeback data select from the one-hot opcode
   always_comb begin
      rd_data_nxt = '0;
      if (i_opcode[OP_RTYPE] | i_opcode[OP_ITYPE])
         rd_data_nxt = i_alu_result;
      else if (i_opcode[OP_LOAD])
         rd_data_nxt = i_load_data;
      else if (i_opcode[OP_JAL] | i_opcode[OP_JALR])
         rd_data_nxt = pc_plus4;
      else if (i_opcode[OP_LUI])
         rd_data_nxt = i_imm;
      else if (i_opcode[OP_AUIPC])
         rd_data_nxt = pc_imm;
   end

`ifdef ASRV32_WB_MISALIGN_TRAP_EN
   state_t          state_d;
   logic            trap_q;
   logic [XLEN-1:0] tval_q;

   assign trap_fire     = accept & taken & (target[1:0] != 2'b00);
   assign trap_ack_fire = (state_q == ST_TRAP) & i_trap_ack;
   assign o_trap        = trap_q;
   assign o_trap_tval   = tval_q;

   // FSM state register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state_q <= ST_RUN;
      else       state_q <= state_d;
   end

   // FSM next state: enter TRAP on a misaligned taken target, leave on acknowledge
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN:  if (trap_fire)  state_d = ST_TRAP;
         ST_TRAP: if (i_trap_ack) state_d = ST_RUN;
         default: state_d = ST_RUN;
      endcase
   end

   // Pending trap flag and faulting target capture
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         trap_q <= 1'b0;
         tval_q <= '0;
      end else if (trap_ack_fire) begin
         trap_q <= 1'b0;
         tval_q <= '0;
      end else if (trap_fire) begin
         trap_q <= 1'b1;
         tval_q <= target;
      end
   end
`else
   logic unused_trap_inputs;

   assign state_q            = ST_RUN;
   assign trap_fire          = 1'b0;
   assign trap_ack_fire      = 1'b0;
   assign o_trap             = 1'b0;
   assign o_trap_tval        = '0;
   assign unused_trap_inputs = &{1'b0, i_trap_ack, i_trap_vector};
`endif

   // Architectural state: PC, writeback registers, strobes and retire counter
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         pc_q       <= PC_RESET;
         rd_data_q  <= '0;
         rd_addr_q  <= '0;
         wr_en_q    <= 1'b0;
         redirect_q <= 1'b0;
         instret_q  <= '0;
      end else begin
         wr_en_q    <= retire & writes_rd;
         redirect_q <= retire & taken;
         if (trap_ack_fire) begin
            pc_q <= i_trap_vector;
         end else if (retire) begin
            pc_q      <= pc_next;
            rd_data_q <= rd_data_nxt;
            rd_addr_q <= i_rd_addr;
            instret_q <= instret_q + CNT_WIDTH'(1);
         end
      end
   end

   assign o_pc       = pc_q;
   assign o_rd_data  = rd_data_q;
   assign o_rd_addr  = rd_addr_q;
   assign o_wr_rd_en = wr_en_q;
   assign o_redirect = redirect_q;
   assign o_instret  = instret_q;

endmodule
